// File: rtl/uart_motor_array_if.sv
// Command/status bundle between the UART byte source and the multi-channel motor driver.
// The master side supplies received bytes; the slave side returns drive and frame status.
interface uart_motor_array_if #(
  parameter int NCH = 2
);
  logic             rx_valid;
  logic [7:0]       rx_byte;
  logic [NCH-1:0]   pwm;
  logic [NCH-1:0]   A;
  logic [NCH-1:0]   B;
  logic [8*NCH-1:0] duty;
  logic             frame_ok;
  logic             frame_err;

  modport master (
    output rx_valid, rx_byte,
    input  pwm, A, B, duty, frame_ok, frame_err
  );

  modport slave (
    input  rx_valid, rx_byte,
    output pwm, A, B, duty, frame_ok, frame_err
  );
endinterface

// File: rtl/uart_motor_array.sv
// Framed UART command parser driving NCH H-bridge channels with soft duty ramping
// and ramp-to-zero direction reversal.
module uart_motor_array #(
  parameter int NCH      = 2,
  parameter int PWM_DIV  = 4,
  parameter int RAMP_DIV = 100000,
  parameter int TIMEOUT  = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  uart_motor_array_if.slave bus
);

  // Encoding chosen so that bridge A = mode[0] and B = mode[1].
  typedef enum logic [1:0] {COAST = 2'b00, FWD = 2'b01, REV = 2'b10, BRAKE = 2'b11} mode_t;
  typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_CMD} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  state_t         state_reg;
  logic [3:0]     ch_reg;
  mode_t          mode_reg;
  logic [TW-1:0]  timer_reg;
  logic           frame_ok_reg;
  logic           frame_err_reg;
  mode_t          pend_mode_reg [NCH];
  logic [7:0]     target_reg    [NCH];

  logic [RW-1:0]  ramp_cnt_reg;
  logic           ramp_tick;
  logic [PW-1:0]  pwm_pre_reg;
  logic           pwm_step;
  logic [7:0]     pwm_cnt_reg;
  logic           timed_out;

  assign timed_out = (timer_reg >= TW'(TIMEOUT - 1));
  assign ramp_tick = (ramp_cnt_reg == RW'(RAMP_DIV - 1));
  assign pwm_step  = (pwm_pre_reg == PW'(PWM_DIV - 1));

  // Parser, inter-byte timer and command commit share one state machine.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      ch_reg        <= 4'd0;
      mode_reg      <= COAST;
      timer_reg     <= '0;
      frame_ok_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        pend_mode_reg[i] <= COAST;
        target_reg[i]    <= 8'd0;
      end
    end else begin
      frame_ok_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      if (bus.rx_valid || state_reg == IDLE) begin
        timer_reg <= '0;
      end else begin
        timer_reg <= timer_reg + TW'(1);
      end
      case (state_reg)
        IDLE: begin
          if (bus.rx_valid && bus.rx_byte[7:4] == 4'hA) begin
            ch_reg    <= bus.rx_byte[3:0];
            state_reg <= GOT_HDR;
          end
        end
        GOT_HDR: begin
          if (bus.rx_valid) begin
            if (bus.rx_byte[7:2] != 6'd0) begin
              frame_err_reg <= 1'b1;
              state_reg     <= IDLE;
            end else begin
              mode_reg  <= mode_t'(bus.rx_byte[1:0]);
              state_reg <= GOT_CMD;
            end
          end else if (timed_out) begin
            frame_err_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        GOT_CMD: begin
          if (bus.rx_valid) begin
            state_reg <= IDLE;
            if ({1'b0, ch_reg} < 5'(NCH)) begin
              frame_ok_reg <= 1'b1;
              for (int i = 0; i < NCH; i++) begin
                if (ch_reg == 4'(i)) begin
                  pend_mode_reg[i] <= mode_reg;
                  target_reg[i]    <= (mode_reg == FWD || mode_reg == REV) ? bus.rx_byte : 8'd0;
                end
              end
            end else begin
              frame_err_reg <= 1'b1;
            end
          end else if (timed_out) begin
            frame_err_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ramp_cnt_reg <= '0;
      pwm_pre_reg  <= '0;
      pwm_cnt_reg  <= 8'd0;
    end else begin
      ramp_cnt_reg <= ramp_tick ? '0 : ramp_cnt_reg + RW'(1);
      pwm_pre_reg  <= pwm_step ? '0 : pwm_pre_reg + PW'(1);
      if (pwm_step) begin
        pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
      end
    end
  end

  assign bus.frame_ok  = frame_ok_reg;
  assign bus.frame_err = frame_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      mode_t      cur_mode_reg;
      logic [7:0] duty_reg;
      logic       a_reg;
      logic       b_reg;
      logic       pwm_reg;

      // A/B update in the same edge as cur_mode, so the bridge never lags the mode.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cur_mode_reg <= COAST;
          duty_reg     <= 8'd0;
          a_reg        <= 1'b0;
          b_reg        <= 1'b0;
          pwm_reg      <= 1'b0;
        end else begin
          pwm_reg <= (cur_mode_reg == FWD || cur_mode_reg == REV) && (pwm_cnt_reg < duty_reg);
          if (ramp_tick) begin
            if (pend_mode_reg[gi] != cur_mode_reg) begin
              if (duty_reg != 8'd0) begin
                duty_reg <= duty_reg - 8'd1;
              end else begin
                cur_mode_reg <= pend_mode_reg[gi];
                a_reg        <= pend_mode_reg[gi][0];
                b_reg        <= pend_mode_reg[gi][1];
              end
            end else if (duty_reg < target_reg[gi]) begin
              duty_reg <= duty_reg + 8'd1;
            end else if (duty_reg > target_reg[gi]) begin
              duty_reg <= duty_reg - 8'd1;
            end
          end
        end
      end

      assign bus.pwm[gi]           = pwm_reg;
      assign bus.A[gi]             = a_reg;
      assign bus.B[gi]             = b_reg;
      assign bus.duty[8*gi +: 8]   = duty_reg;
    end
  endgenerate

endmodule

// File: tb/tb_uart_motor_array.sv
// Directed bench for uart_motor_array: frame results go through a scoreboard queue,
// channel behaviour is checked at directed points.
module tb_uart_motor_array;

  localparam int NCH      = 2;
  localparam int PWM_DIV  = 1;
  localparam int RAMP_DIV = 4;
  localparam int TIMEOUT  = 20;
  localparam logic [31:0] EV_OK  = 32'd1;
  localparam logic [31:0] EV_ERR = 32'd2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_motor_array_if #(.NCH(NCH)) bus ();

  uart_motor_array #(
    .NCH(NCH), .PWM_DIV(PWM_DIV), .RAMP_DIV(RAMP_DIV), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] duty_of(input int ch);
    return bus.duty[8*ch +: 8];
  endfunction

  function automatic logic [1:0] ab_of(input int ch);
    return {bus.A[ch], bus.B[ch]};
  endfunction

  // Every frame_ok/frame_err pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (bus.frame_ok || bus.frame_err) begin
      if (sb.size() == 0) begin
        check("frame_unexpected", {30'd0, bus.frame_err, bus.frame_ok}, 32'd0);
      end else begin
        check("frame_evt", {30'd0, bus.frame_err, bus.frame_ok}, sb.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
  endtask

  task automatic expect_drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [31:0] ev, input string tag);
    sb.push_back(ev);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    expect_drain(tag, 10);
  endtask

  task automatic wait_duty(input int ch, input logic [7:0] v, input int budget, input string tag);
    int n = 0;
    while (duty_of(ch) !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, duty_of(ch), v);
  endtask

  task automatic wait_ab(input int ch, input logic [1:0] v, input int budget, input string tag);
    int n = 0;
    while (ab_of(ch) !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, ab_of(ch), v);
  endtask

  task automatic count_pwm(input int ch, output int hi);
    hi = 0;
    repeat (256) begin
      @(negedge clk);
      if (bus.pwm[ch] === 1'b1) hi++;
    end
  endtask

  initial begin
    int hi;
    int n;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pwm", bus.pwm, 0);
    check("rst_A", bus.A, 0);
    check("rst_B", bus.B, 0);
    check("rst_duty", bus.duty, 0);
    check("rst_pulses", {bus.frame_ok, bus.frame_err}, 0);
    @(posedge clk); #1 reset = 1'b1;

    // Channel 0 forward, ramp to 16
    send_frame(8'hA0, 8'h01, 8'h10, EV_OK, "s1_frame_ok");
    wait_ab(0, 2'b10, 50, "s1_ab_fwd");
    check("s1_duty_at_switch", duty_of(0), 0);
    wait_duty(0, 8'd16, 200, "s1_duty16");
    check("s1_ch1_duty", duty_of(1), 0);
    check("s1_ch1_ab", ab_of(1), 2'b00);
    count_pwm(0, hi);
    check("s1_pwm0_high", hi, 16);
    check("s1_duty_sat", duty_of(0), 16);

    // Reverse: ramp to zero before the bridge flips
    send_frame(8'hA0, 8'h02, 8'h08, EV_OK, "s2_frame_ok");
    n = 0;
    while (ab_of(0) === 2'b10 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("s2_ab_rev", ab_of(0), 2'b01);
    check("s2_duty_at_flip", duty_of(0), 0);
    wait_duty(0, 8'd8, 200, "s2_duty8");

    // Rejected frames leave channel state untouched
    send_frame(8'hA5, 8'h01, 8'h40, EV_ERR, "s3_bad_ch");
    check("s3_duty0", duty_of(0), 8);
    check("s3_ab0", ab_of(0), 2'b01);
    check("s3_duty1", duty_of(1), 0);
    sb.push_back(EV_ERR);
    send_byte(8'hA1);
    send_byte(8'h05);
    expect_drain("s3_bad_mode", 10);
    send_byte(8'h10);
    repeat (40) @(negedge clk);
    check("s3_ch1_idle", {ab_of(1), duty_of(1)}, 0);

    // Partial frame times out
    sb.push_back(EV_ERR);
    send_byte(8'hA1);
    send_byte(8'h01);
    repeat (TIMEOUT - 5) @(negedge clk);
    check("s4_not_early", sb.size(), 1);
    repeat (10) @(negedge clk);
    check("s4_timeout", sb.size(), 0);

    // Channel 1 to full duty
    send_frame(8'hA1, 8'h01, 8'hFF, EV_OK, "s4_frame_ok");
    wait_duty(1, 8'd255, 1500, "s4_duty255");
    check("s4_ab1", ab_of(1), 2'b10);
    count_pwm(1, hi);
    check("s4_pwm1_low", 256 - hi, 1);
    check("s4_ch0_kept", duty_of(0), 8);

    // Brake ignores byte2 and ramps out
    send_frame(8'hA0, 8'h03, 8'h99, EV_OK, "s5_frame_ok");
    wait_ab(0, 2'b11, 100, "s5_ab_brake");
    check("s5_duty0", duty_of(0), 0);
    count_pwm(0, hi);
    check("s5_pwm0_off", hi, 0);
    check("s5_duty0_stays", duty_of(0), 0);
    check("s5_ch1_kept", duty_of(1), 255);

    // Asynchronous reset mid-ramp and mid-frame
    send_frame(8'hA0, 8'h01, 8'hFF, EV_OK, "s6_frame_ok");
    wait_duty(0, 8'd5, 200, "s6_ramp");
    send_byte(8'hA1);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    check("s6_rst_pwm", bus.pwm, 0);
    check("s6_rst_ab", {bus.A, bus.B}, 0);
    check("s6_rst_duty", bus.duty, 0);
    check("s6_rst_pulses", {bus.frame_ok, bus.frame_err}, 0);
    @(posedge clk); #1 reset = 1'b1;
    send_frame(8'hA1, 8'h01, 8'h20, EV_OK, "s6_post_frame");
    wait_duty(1, 8'h20, 400, "s6_ch1_duty");
    check("s6_ch1_ab", ab_of(1), 2'b10);
    check("s6_ch0_idle", {ab_of(0), duty_of(0)}, 0);

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
